// File: rtl/vie_axi_bridge_if.sv
// rtl/vie_axi_bridge_if.sv - AXI3 channel bundle between vie_axi_bridge (master) and memory (slave)
interface vie_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/vie_axi_bridge.sv
// rtl/vie_axi_bridge.sv - SRAM-like inst/data ports to single-beat AXI3 master; VIE_RAW_CHECK_EN narrows read-after-write blocking to same word
module vie_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  vie_axi_bridge_if.master  axi
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic              ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [1:0]        ar_size_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [1:0]        aw_size_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_done_q;
  logic              w_done_q;

  logic              data_rd;
  logic              data_rd_block;
  logic              rd_take_data;
  logic              rd_take_inst;
  logic              wr_take;
  logic              r_fire;
  logic              r_to_data;
  logic              r_data_ret;
  logic              aw_fire;
  logic              w_fire;
  logic              b_fire;
  logic [STRB_W-1:0] strb_calc;
  logic              unused_axi;

  assign data_rd = data_req & ~data_wr;

`ifdef VIE_RAW_CHECK_EN
  assign data_rd_block = (w_state != W_IDLE) && (aw_addr_q[ADDR_W-1:2] == data_addr[ADDR_W-1:2]);
`else
  assign data_rd_block = (w_state != W_IDLE);
`endif

  // A data read always wins the read channel, even when it is itself blocked by a write.
  assign rd_take_data = (r_state == R_IDLE) & data_rd & ~data_rd_block;
  assign rd_take_inst = (r_state == R_IDLE) & inst_req & ~data_rd;
  assign wr_take      = data_req & data_wr & (w_state == W_IDLE) & ~((r_state == R_AR) & ar_id_q);

  assign inst_addr_ok = rd_take_inst;
  assign data_addr_ok = rd_take_data | wr_take;

  assign r_to_data    = (axi.rid == 4'd1);
  assign r_fire       = axi.rvalid & axi.rready;
  assign r_data_ret   = (r_state == R_R) & axi.rvalid & r_to_data;
  assign inst_data_ok = r_fire & ~r_to_data;
  assign data_data_ok = (r_fire & r_to_data) | b_fire;
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  always_comb begin
    r_next      = r_state;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    case (r_state)
      R_IDLE: if (rd_take_data | rd_take_inst) r_next = R_AR;
      R_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) r_next = R_R;
      end
      R_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // A data read return owns data_data_ok; the write response waits one cycle.
  always_comb begin
    w_next      = w_state;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    b_fire      = 1'b0;
    case (w_state)
      W_IDLE: if (wr_take) w_next = W_AW;
      W_AW: begin
        axi.awvalid = ~aw_done_q;
        axi.wvalid  = ~w_done_q;
        aw_fire     = ~aw_done_q & axi.awready;
        w_fire      = ~w_done_q & axi.wready;
        if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) w_next = W_B;
      end
      W_B: begin
        axi.bready = ~r_data_ret;
        b_fire     = axi.bvalid & ~r_data_ret;
        if (b_fire) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    case (data_size)
      2'd0:    strb_calc = STRB_W'(4'b0001) << data_addr[1:0];
      2'd1:    strb_calc = STRB_W'(4'b0011) << {data_addr[1], 1'b0};
      default: strb_calc = STRB_W'(4'b1111);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_id_q   <= 1'b0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (rd_take_data | rd_take_inst) begin
        ar_id_q   <= rd_take_data;
        ar_addr_q <= rd_take_data ? data_addr : inst_addr;
        ar_size_q <= rd_take_data ? data_size : inst_size;
      end
      if (wr_take) begin
        aw_addr_q <= data_addr;
        aw_size_q <= data_size;
        w_data_q  <= data_wdata;
        w_strb_q  <= strb_calc;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
    end
  end

  assign axi.arid    = {3'b000, ar_id_q};
  assign axi.araddr  = ar_addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, ar_size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.awid    = 4'd1;
  assign axi.awaddr  = aw_addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, aw_size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = 4'd1;
  assign axi.wdata   = w_data_q;
  assign axi.wstrb   = w_strb_q;
  assign axi.wlast   = 1'b1;

  assign unused_axi = ^{axi.rresp, axi.rlast, axi.bid, axi.bresp};
endmodule

// File: tb/tb_vie_axi_bridge.sv
// tb/tb_vie_axi_bridge.sv - directed self-checking bench for vie_axi_bridge
module tb_vie_axi_bridge;
  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  v_size [0:5];
  logic [31:0] v_addr [0:5];
  logic [3:0]  v_strb [0:5];

  vie_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  vie_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    resetn = 1'b0; inst_req = 1'b0; inst_size = 2'd0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b1; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = 4'd1; axi.bresp = '0; axi.bvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", axi.arvalid); end
    n_tests++; if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", axi.rready); end
    n_tests++; if (axi.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %b want 0", axi.awvalid); end
    n_tests++; if (axi.wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid: got %b want 0", axi.wvalid); end
    n_tests++; if (axi.bready !== 1'b0) begin n_fail++; $display("FAIL rst_bready: got %b want 0", axi.bready); end
    n_tests++; if (axi.arid !== 4'd0) begin n_fail++; $display("FAIL rst_arid: got %h want 0", axi.arid); end
    n_tests++; if (axi.araddr !== 32'd0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", axi.araddr); end
    n_tests++; if (axi.wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", axi.wdata); end
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL rst_data_ok: got %b want 00", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_inst_read();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
    #1;
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t1_addr_ok: got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    n_tests++; if (axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL t1_arvalid: got %b want 1", axi.arvalid); end
    n_tests++; if (axi.arid !== 4'd0) begin n_fail++; $display("FAIL t1_arid: got %h want 0", axi.arid); end
    n_tests++; if (axi.araddr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL t1_araddr: got %h want bfc00000", axi.araddr); end
    n_tests++; if (axi.arsize !== 3'd2) begin n_fail++; $display("FAIL t1_arsize: got %0d want 2", axi.arsize); end
    n_tests++; if ({axi.arlen, axi.arburst} !== 6'b0000_01) begin n_fail++; $display("FAIL t1_arlen_burst: got %b want 000001", {axi.arlen, axi.arburst}); end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    #1;
    n_tests++; if ({axi.arvalid, axi.rready} !== 2'b01) begin n_fail++; $display("FAIL t1_rwait: got %b want 01", {axi.arvalid, axi.rready}); end
    repeat (2) @(negedge clk);
    @(negedge clk);
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h3C1D_BFC1;
    #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL t1_data_ok: got %b want 10", {inst_data_ok, data_data_ok}); end
    n_tests++; if (inst_rdata !== 32'h3C1D_BFC1) begin n_fail++; $display("FAIL t1_rdata: got %h want 3c1dbfc1", inst_rdata); end
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    n_tests++; if ({inst_data_ok, axi.rready} !== 2'b00) begin n_fail++; $display("FAIL t1_after: got %b want 00", {inst_data_ok, axi.rready}); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0000_1000; inst_size = 2'd2;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_size = 2'd2;
    #1;
    n_tests++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL t2_prio: got %b want 10", {data_addr_ok, inst_addr_ok}); end
    @(negedge clk);
    data_req = 1'b0;
    #1;
    n_tests++; if (axi.arid !== 4'd1 || axi.araddr !== 32'h0000_2000) begin n_fail++; $display("FAIL t2_ar_data: got id %h addr %h want 1 00002000", axi.arid, axi.araddr); end
    n_tests++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL t2_inst_wait: got %b want 0", inst_addr_ok); end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h1122_3344;
    #1;
    n_tests++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin n_fail++; $display("FAIL t2_dret: got %b want 100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
    n_tests++; if (data_rdata !== 32'h1122_3344) begin n_fail++; $display("FAIL t2_drdata: got %h want 11223344", data_rdata); end
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t2_inst_ok: got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    n_tests++; if (axi.arid !== 4'd0 || axi.araddr !== 32'h0000_1000 || axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL t2_ar_inst: got id %h addr %h v %b want 0 00001000 1", axi.arid, axi.araddr, axi.arvalid); end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h5566_7788;
    #1;
    n_tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL t2_iret: got %b want 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    axi.rvalid = 1'b0;
  endtask

  task automatic test_write_split();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0103; data_wdata = 32'hAB00_0000;
    #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t3_addr_ok: got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0;
    #1;
    n_tests++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin n_fail++; $display("FAIL t3_valids: got %b want 11", {axi.awvalid, axi.wvalid}); end
    n_tests++; if (axi.wstrb !== 4'b1000) begin n_fail++; $display("FAIL t3_wstrb: got %b want 1000", axi.wstrb); end
    n_tests++; if (axi.awaddr !== 32'h0000_0103 || axi.awsize !== 3'd0 || axi.wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL t3_aw: got %h %0d %h want 00000103 0 ab000000", axi.awaddr, axi.awsize, axi.wdata); end
    n_tests++; if ({axi.awid, axi.wid, axi.wlast} !== 9'b0001_0001_1) begin n_fail++; $display("FAIL t3_ids: got %h %h %b want 1 1 1", axi.awid, axi.wid, axi.wlast); end
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    #1;
    n_tests++; if ({axi.awvalid, axi.wvalid} !== 2'b01) begin n_fail++; $display("FAIL t3_aw_drop: got %b want 01", {axi.awvalid, axi.wvalid}); end
    @(negedge clk);
    #1;
    n_tests++; if ({axi.awvalid, axi.wvalid, data_data_ok} !== 3'b010) begin n_fail++; $display("FAIL t3_no_aw2: got %b want 010", {axi.awvalid, axi.wvalid, data_data_ok}); end
    axi.wready = 1'b1;
    @(negedge clk);
    axi.wready = 1'b0;
    #1;
    n_tests++; if ({axi.awvalid, axi.wvalid, axi.bready, data_data_ok} !== 4'b0010) begin n_fail++; $display("FAIL t3_wb: got %b want 0010", {axi.awvalid, axi.wvalid, axi.bready, data_data_ok}); end
    axi.bvalid = 1'b1;
    #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL t3_bresp: got %b want 1", data_data_ok); end
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    n_tests++; if ({data_data_ok, axi.bready} !== 2'b00) begin n_fail++; $display("FAIL t3_done: got %b want 00", {data_data_ok, axi.bready}); end
  endtask

  task automatic test_wstrb();
    v_size = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0};
    v_addr = '{32'h0000_0000, 32'h0000_0202, 32'h0000_0200, 32'h0000_0001, 32'h0000_0004, 32'h0000_0001};
    v_strb = '{4'b0001, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_size = v_size[i]; data_addr = v_addr[i]; data_wdata = 32'h5A5A_0000 + i;
      #1;
      n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wstrb_ok[%0d]: got %b want 1", i, data_addr_ok); end
      @(negedge clk);
      data_req = 1'b0; data_wr = 1'b0;
      #1;
      n_tests++; if (axi.wstrb !== v_strb[i] || axi.awsize !== {1'b0, v_size[i]}) begin n_fail++; $display("FAIL wstrb[%0d]: got %b size %0d want %b size %0d", i, axi.wstrb, axi.awsize, v_strb[i], {1'b0, v_size[i]}); end
      axi.awready = 1'b1; axi.wready = 1'b1;
      @(negedge clk);
      axi.awready = 1'b0; axi.wready = 1'b0;
      #1;
      n_tests++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin n_fail++; $display("FAIL wstrb_same_cycle[%0d]: got %b want 001", i, {axi.awvalid, axi.wvalid, axi.bready}); end
      axi.bvalid = 1'b1;
      @(negedge clk);
      axi.bvalid = 1'b0;
    end
  endtask

  task automatic test_raw_block();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0100; data_wdata = 32'h1234_5678;
    @(negedge clk);
    data_wr = 1'b0; data_addr = 32'h0000_0200;
    #1;
`ifdef VIE_RAW_CHECK_EN
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t4_raw_en: got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b1;
    @(negedge clk);
    axi.bvalid = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd1;
    #1;
    n_tests++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL t4_rret: got %b want 1", data_data_ok); end
    @(negedge clk);
    axi.rvalid = 1'b0;
`else
    n_tests++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL t4_block_aw: got %b want 0", data_addr_ok); end
    axi.awready = 1'b1; axi.wready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0; axi.wready = 1'b0;
    #1;
    n_tests++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL t4_block_b: got %b want 0", data_addr_ok); end
    axi.bvalid = 1'b1;
    #1;
    n_tests++; if ({data_addr_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL t4_bvalid: got %b want 01", {data_addr_ok, data_data_ok}); end
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t4_unblock: got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    #1;
    n_tests++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0000_0200) begin n_fail++; $display("FAIL t4_ar: got %b %h want 1 00000200", axi.arvalid, axi.araddr); end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd1;
    @(negedge clk);
    axi.rvalid = 1'b0;
`endif
  endtask

  task automatic test_inst_vs_write();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0500; data_wdata = 32'h0BAD_CAFE;
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0500; inst_size = 2'd2;
    #1;
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL inst_vs_wr_ok: got %b want 1", inst_addr_ok); end
    axi.awready = 1'b1; axi.wready = 1'b1;
    @(negedge clk);
    inst_req = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.bvalid = 1'b1;
    #1;
    n_tests++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin n_fail++; $display("FAIL inst_vs_wr_b: got %b want 10", {data_data_ok, inst_data_ok}); end
    @(negedge clk);
    axi.bvalid = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h0000_0ACE;
    #1;
    n_tests++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin n_fail++; $display("FAIL inst_vs_wr_r: got %b want 01", {data_data_ok, inst_data_ok}); end
    @(negedge clk);
    axi.rvalid = 1'b0;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300; data_size = 2'd2;
    #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t5_rd_ok: got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0400; data_wdata = 32'h0F0F_0F0F;
    #1;
    n_tests++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t5_wr_ok: got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0;
    axi.awready = 1'b1; axi.wready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'hCAFE_F00D; axi.bvalid = 1'b1;
    #1;
    n_tests++; if ({data_data_ok, axi.bready} !== 2'b10) begin n_fail++; $display("FAIL t5_first: got %b want 10", {data_data_ok, axi.bready}); end
    n_tests++; if (data_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL t5_rdata: got %h want cafef00d", data_rdata); end
    @(negedge clk);
    axi.rvalid = 1'b0;
    #1;
    n_tests++; if ({data_data_ok, axi.bready} !== 2'b11) begin n_fail++; $display("FAIL t5_second: got %b want 11", {data_data_ok, axi.bready}); end
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    n_tests++; if ({data_data_ok, axi.bready} !== 2'b00) begin n_fail++; $display("FAIL t5_third: got %b want 00", {data_data_ok, axi.bready}); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0000_0600; inst_size = 2'd2;
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    n_tests++; if (axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL t6_pre: got %b want 1", axi.arvalid); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_tests++; if ({axi.arvalid, axi.rready} !== 2'b00 || axi.araddr !== 32'd0) begin n_fail++; $display("FAIL t6_rst: got %b %h want 00 00000000", {axi.arvalid, axi.rready}, axi.araddr); end
    inst_req = 1'b1; inst_addr = 32'h0000_0700;
    #1;
    n_tests++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL t6_accept: got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    n_tests++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0000_0700) begin n_fail++; $display("FAIL t6_ar: got %b %h want 1 00000700", axi.arvalid, axi.araddr); end
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h0000_0777;
    #1;
    n_tests++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_0777) begin n_fail++; $display("FAIL t6_ret: got %b %h want 1 00000777", inst_data_ok, inst_rdata); end
    @(negedge clk);
    axi.rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_arbitration();
    test_write_split();
    test_wstrb();
    test_raw_block();
    test_inst_vs_write();
    test_same_cycle();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
